// File: rtl/video_fetch_if.sv
// Video fetch scheduler handshake bundle: line timing, mode bits, arbiter grant/return, status.
// Latency: n/a (wires only).
// Backpressure: video_go is the request; the arbiter throttles it via video_next.
// Ports: master = timing/arbiter side (drives line_start..video_strobe); slave = scheduler.
interface video_fetch_if;
  logic       line_start;
  logic       vpix;
  logic       int_start;
  logic       mode_zx;
  logic       mode_p_hmclr;
  logic       mode_p_16c;
  logic       mode_ag;
  logic       mode_a_text;
  logic       video_next;
  logic       video_strobe;
  logic       video_go;
  logic [6:0] words_left;
  logic [2:0] outstanding;
  logic       line_done;
  logic       overrun;
  logic       strobe_err;

  modport master (
    output line_start, vpix, int_start,
    output mode_zx, mode_p_hmclr, mode_p_16c, mode_ag, mode_a_text,
    output video_next, video_strobe,
    input  video_go, words_left, outstanding, line_done, overrun, strobe_err
  );

  modport slave (
    input  line_start, vpix, int_start,
    input  mode_zx, mode_p_hmclr, mode_p_16c, mode_ag, mode_a_text,
    input  video_next, video_strobe,
    output video_go, words_left, outstanding, line_done, overrun, strobe_err
  );
endinterface

// File: rtl/video_fetch_sched.sv
// Per-line video word fetch scheduler: loads a word count per visible line, requests slots, tracks returns.
// Latency: all outputs registered; video_go reflects a grant/strobe one cycle after it happens.
// Backpressure: video_go drops while outstanding == OUT_MAX and reasserts the cycle after a return.
// Ports: clk, rst_n (sync, active-low), vif (slave modport of video_fetch_if).
module video_fetch_sched #(
  parameter int WORDS_ZX   = 32,
  parameter int WORDS_PHM  = 32,
  parameter int WORDS_P16C = 64,
  parameter int WORDS_ATM  = 80,
  parameter int OUT_MAX    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  video_fetch_if.slave   vif
);

  localparam logic [2:0] OUT_MAX_V = 3'(OUT_MAX);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t     state_q, state_d;
  logic [6:0] words_left_q, words_left_d;
  logic [2:0] outstanding_q, outstanding_d;
  logic       go_q, go_d;
  logic       line_done_q, line_done_d;
  logic       overrun_q, overrun_d;
  logic       strobe_err_q, strobe_err_d;

  logic [6:0] line_count;
  logic       grant;
  logic       load;

  // Mode priority: atm (text or gfx) > pentagon 16c > pentagon hmclr > zx.
  always_comb begin
    line_count = 7'd0;
    if (vif.mode_a_text || vif.mode_ag) line_count = 7'(WORDS_ATM);
    else if (vif.mode_p_16c)            line_count = 7'(WORDS_P16C);
    else if (vif.mode_p_hmclr)          line_count = 7'(WORDS_PHM);
    else if (vif.mode_zx)               line_count = 7'(WORDS_ZX);
  end

  // A grant only counts against our own registered request.
  assign grant = vif.video_next && go_q;
  // A zero-word mode is a no-op line: nothing loads, nothing is flagged.
  assign load  = vif.line_start && vif.vpix && (line_count != 7'd0);

  always_comb begin
    state_d       = state_q;
    words_left_d  = words_left_q;
    outstanding_d = outstanding_q;
    line_done_d   = 1'b0;
    overrun_d     = overrun_q;
    strobe_err_d  = strobe_err_q;

    unique case ({grant, vif.video_strobe})
      2'b10: if (outstanding_q < OUT_MAX_V) outstanding_d = outstanding_q + 3'd1;
      2'b01: begin
        if (outstanding_q != 3'd0) outstanding_d = outstanding_q - 3'd1;
        else                       strobe_err_d  = 1'b1;
      end
      2'b11: if (outstanding_q == 3'd0) strobe_err_d = 1'b1;
      default: ;
    endcase

    if (grant && words_left_q != 7'd0) words_left_d = words_left_q - 7'd1;

    unique case (state_q)
      FETCH: if (words_left_d == 7'd0) state_d = DRAIN;
      DRAIN: if (outstanding_q == 3'd0) begin
        state_d     = IDLE;
        line_done_d = 1'b1;
      end
      default: ;
    endcase

    // A new line aborts whatever is in progress; in-flight words are still owed to us.
    if (load) begin
      if (state_q != IDLE) overrun_d = 1'b1;
      words_left_d = line_count;
      state_d      = FETCH;
      line_done_d  = 1'b0;
    end

    // Frame start wins over everything else in the same cycle.
    if (vif.int_start) begin
      state_d       = IDLE;
      words_left_d  = 7'd0;
      outstanding_d = 3'd0;
      line_done_d   = 1'b0;
      overrun_d     = 1'b0;
      strobe_err_d  = 1'b0;
    end

    go_d = (state_d == FETCH) && (words_left_d != 7'd0) && (outstanding_d < OUT_MAX_V);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      words_left_q  <= 7'd0;
      outstanding_q <= 3'd0;
      go_q          <= 1'b0;
      line_done_q   <= 1'b0;
      overrun_q     <= 1'b0;
      strobe_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      words_left_q  <= words_left_d;
      outstanding_q <= outstanding_d;
      go_q          <= go_d;
      line_done_q   <= line_done_d;
      overrun_q     <= overrun_d;
      strobe_err_q  <= strobe_err_d;
    end
  end

  assign vif.video_go    = go_q;
  assign vif.words_left  = words_left_q;
  assign vif.outstanding = outstanding_q;
  assign vif.line_done   = line_done_q;
  assign vif.overrun     = overrun_q;
  assign vif.strobe_err  = strobe_err_q;

endmodule
